// File: rtl/color_boton_sync.sv
// Colour push-button conditioning: two-flop synchroniser, counter debounce and press
// strobe per button, with toggled enables applied to the RGB stage only at frame boundaries.

module color_boton_deb #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic reloj,
  input  logic resetM,
  input  logic btn_i,
  output logic pulse_o
);
  typedef enum logic {ST_STABLE, ST_COUNT} st_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  st_e              st_q;
  logic             s1_q, s2_q, deb_q, deb_prev_q, pulse_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      st_q       <= ST_STABLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      deb_prev_q <= deb_q;
      // Strobe lands one clock after the debounced state rises; releases are silent.
      pulse_q    <= deb_q & ~deb_prev_q;
      case (st_q)
        ST_STABLE: begin
          if (s2_q != deb_q) begin
            st_q  <= ST_COUNT;
            cnt_q <= CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (s2_q == deb_q) begin
            st_q  <= ST_STABLE;
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            deb_q <= s2_q;
            st_q  <= ST_STABLE;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: st_q <= ST_STABLE;
      endcase
    end
  end

  assign pulse_o = pulse_q;
endmodule

module color_boton_sync #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       Boton_R_in,
  input  logic       Boton_G_in,
  input  logic       Boton_B_in,
  input  logic       V_ON,
  output logic       BotonR,
  output logic       BotonG,
  output logic       BotonB,
  output logic [2:0] press_pulse
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] raw, pulse;
  logic [NUM_LANES-1:0] pend_q, rgb_q;
  logic                 v_on_d_q;

  assign raw = {Boton_R_in, Boton_G_in, Boton_B_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    color_boton_deb #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .reloj  (reloj),
      .resetM (resetM),
      .btn_i  (raw[i]),
      .pulse_o(pulse[i])
    );
  end

  // A toggle coinciding with the frame edge misses it: rgb takes the pre-toggle pend.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      v_on_d_q <= 1'b0;
      pend_q   <= '0;
      rgb_q    <= '0;
    end else begin
      v_on_d_q <= V_ON;
      pend_q   <= pend_q ^ pulse;
      if (v_on_d_q && !V_ON) rgb_q <= pend_q;
    end
  end

  assign press_pulse = pulse;
  assign BotonR      = rgb_q[2];
  assign BotonG      = rgb_q[1];
  assign BotonB      = rgb_q[0];
endmodule
